// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared constants and types for the GEMM operand feeder
//
// Contents:
//   DEF_DATA_W, DEF_HOP_LAT, DEF_PE_LAT : default operand width and latencies
//   feeder_state_t                      : feeder control FSM states
//   drain_cycles()                      : cycles from the last operand entering
//                                         the array until the far-corner PE
//                                         accumulator holds its final sum

package gemm_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_HOP_LAT = 2;
    localparam int DEF_PE_LAT  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    // The last operand pair reaches PE (ROWS-1, COLS-1) after (ROWS-1) + (COLS-1)
    // passthrough hops, and that PE then needs PE_LAT cycles to fold it in.
    function automatic int drain_cycles(input int hop, input int rows,
                                        input int cols, input int pe);
        return hop * (rows + cols - 2) + pe;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - data+valid shift register used to skew one array lane
//
// Parameters:
//   DEPTH  : number of register stages; 0 makes the lane a plain wire
//   DATA_W : lane data width
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : synchronous clear of every stage (data and valid)
//   in_data        : lane data entering the line
//   in_valid       : lane valid entering the line
//   out_data       : delayed data, zero whenever out_valid is low
//   out_valid      : delayed valid

module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Control inputs are meaningless for a zero-length line.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, clear};

            assign out_data  = in_data;
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [DATA_W-1:0] data_q  [DEPTH];
            logic              valid_q [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i]  <= '0;
                        valid_q[i] <= 1'b0;
                    end
                end else if (clear) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i]  <= '0;
                        valid_q[i] <= 1'b0;
                    end
                end else begin
                    // Bubbles enter as zero data so the array edge never sees
                    // stale operands on an invalid slot.
                    data_q[0]  <= in_valid ? in_data : '0;
                    valid_q[0] <= in_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        data_q[i]  <= data_q[i-1];
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            assign out_data  = data_q[DEPTH-1];
            assign out_valid = valid_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewed operand feeder and tile sequencer for a systolic GEMM array
//
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   flush                    : synchronous abort of the current tile
//   in_valid/in_ready        : beat handshake; in_last marks the final k-beat
//   in_a [ROWS*DATA_W]       : one A column slice, lane r at [r*DATA_W +: DATA_W]
//   in_b [COLS*DATA_W]       : one B row slice,    lane c at [c*DATA_W +: DATA_W]
//   a_lane/a_lane_valid      : skewed A operands to the array left edge
//   b_lane/b_lane_valid      : skewed B operands to the array top edge
//   start_tile               : one-cycle accumulator clear broadcast
//   tile_done                : one-cycle pulse once every PE holds its final sum
//   beat_cnt                 : beats accepted in the current tile

module systolic_feeder
    import gemm_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int HOP_LAT = DEF_HOP_LAT,
    parameter int PE_LAT  = DEF_PE_LAT,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_a,
    input  logic [COLS*DATA_W-1:0] in_b,
    input  logic                   in_last,
    output logic [ROWS*DATA_W-1:0] a_lane,
    output logic [ROWS-1:0]        a_lane_valid,
    output logic [COLS*DATA_W-1:0] b_lane,
    output logic [COLS-1:0]        b_lane_valid,
    output logic                   start_tile,
    output logic                   tile_done,
    output logic [CNT_W-1:0]       beat_cnt
);

    localparam int DRAIN_LOAD = drain_cycles(HOP_LAT, ROWS, COLS, PE_LAT);
    localparam int DRAIN_W    = $clog2(DRAIN_LOAD + 1);

    feeder_state_t          state;
    logic [DRAIN_W-1:0]     drain_cnt;
    logic                   accept;

    // Input capture stage: supplies the common one-cycle latency shared by
    // every lane; the per-lane delay lines add only the skew on top of it.
    logic [ROWS*DATA_W-1:0] a_cap;
    logic [COLS*DATA_W-1:0] b_cap;
    logic                   cap_valid;

    // A beat flushed in the same cycle it is offered is dropped, not counted.
    assign accept = in_valid && in_ready && !flush;

    // ------------------------------------------------------------------
    // Control FSM (all outputs registered)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            start_tile <= 1'b0;
            tile_done  <= 1'b0;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
        end else if (flush) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            start_tile <= 1'b0;
            tile_done  <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tile_done <= 1'b0;
                    // The waiting beat is left on the bus; it is taken in STREAM.
                    if (in_valid) begin
                        state      <= CLEAR;
                        start_tile <= 1'b1;
                        beat_cnt   <= '0;
                    end
                end

                CLEAR: begin
                    state      <= STREAM;
                    start_tile <= 1'b0;
                    in_ready   <= 1'b1;
                    beat_cnt   <= '0;
                end

                STREAM: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (in_last) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= DRAIN_W'(DRAIN_LOAD);
                        end
                    end
                end

                DRAIN: begin
                    // tile_done rises together with the count reaching zero and
                    // is held for exactly the one cycle spent at zero.
                    if (drain_cnt == '0) begin
                        state     <= IDLE;
                        tile_done <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                        tile_done <= (drain_cnt == DRAIN_W'(1));
                    end
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cap     <= '0;
            b_cap     <= '0;
            cap_valid <= 1'b0;
        end else if (flush) begin
            a_cap     <= '0;
            b_cap     <= '0;
            cap_valid <= 1'b0;
        end else begin
            a_cap     <= accept ? in_a : '0;
            b_cap     <= accept ? in_b : '0;
            cap_valid <= accept;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane skew: lane i trails lane 0 by HOP_LAT*i cycles so that the
    // wavefront of one k-beat meets each PE on the same cycle.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH  (HOP_LAT * r),
            .DATA_W (DATA_W)
        ) u_row_dl (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .in_data   (a_cap[r*DATA_W +: DATA_W]),
            .in_valid  (cap_valid),
            .out_data  (a_lane[r*DATA_W +: DATA_W]),
            .out_valid (a_lane_valid[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_delay_line #(
            .DEPTH  (HOP_LAT * c),
            .DATA_W (DATA_W)
        ) u_col_dl (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .in_data   (b_cap[c*DATA_W +: DATA_W]),
            .in_valid  (cap_valid),
            .out_data  (b_lane[c*DATA_W +: DATA_W]),
            .out_valid (b_lane_valid[c])
        );
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 16, operand width.
- ROWS, 4, array rows (A lanes).
- COLS, 4, array columns (B lanes).
- HOP_LAT, 2, PE-to-PE passthrough latency in cycles.
- PE_LAT, 3, cycles from operand entry at a PE to its accumulator update being visible on psum_out.
- CNT_W, 16, beat counter width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous abort.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_a  in  ROWS*DATA_W  A column slice; lane r at [r*DATA_W +: DATA_W].
- in_b  in  COLS*DATA_W  B row slice; lane c at [c*DATA_W +: DATA_W].
- in_last  in  1  marks final beat (k = K-1) of the tile.
- a_lane  out  ROWS*DATA_W  skewed A data to array left edge.
- a_lane_valid  out  ROWS  per-row valid.
- b_lane  out  COLS*DATA_W  skewed B data to array top edge.
- b_lane_valid  out  COLS  per-column valid.
- start_tile  out  1  accumulator clear, broadcast to all PEs.
- tile_done  out  1  one-cycle pulse when every PE accumulator holds the final sum.
- beat_cnt  out  CNT_W  beats accepted in the current tile.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, STREAM, DRAIN.
REQ-004 IDLE: in_ready=0; when in_valid=1, go to CLEAR (the beat is not consumed).
REQ-005 CLEAR: start_tile=1 for exactly one cycle, in_ready=0, beat_cnt cleared to 0; next state STREAM.
REQ-006 STREAM: in_ready=1; each accepted beat increments beat_cnt (wraps at 2^CNT_W); an accepted beat with in_last=1 moves to DRAIN.
REQ-007 STREAM cycles with in_valid=0 SHALL inject bubbles (lane valid=0) that propagate through the skew unchanged.
REQ-008 Row lane r SHALL present an accepted A element with total latency 1+HOP_LAT*r cycles after the accepting edge; column lane c with latency 1+HOP_LAT*c; valid bits travel with data.
REQ-009 DRAIN: in_ready=0; a counter loads HOP_LAT*(ROWS+COLS-2)+PE_LAT at entry and decrements each cycle; tile_done pulses when the count reaches 0 (exactly 15 cycles after the in_last accepting edge at defaults); then go to IDLE.
REQ-010 Invalid lane data SHALL be driven as zero.
REQ-011 flush SHALL force IDLE next cycle and clear all delay-line valids, the drain counter, start_tile and tile_done; flush has priority over in_last, drain completion and CLEAR.
REQ-012 A new tile SHALL NOT start before tile_done of the previous tile; back-to-back tiles pass through IDLE→CLEAR, costing 2 cycles of in_ready=0.
REQ-013 Accumulator width is owned by the PE; this block performs no arithmetic on data.

Reset
REQ-014 While rst=1: state=IDLE, in_ready=0, start_tile=0, tile_done=0, beat_cnt=0, all lane data and valids=0, drain counter=0.
REQ-015 Reset asserted mid-STREAM or mid-DRAIN SHALL discard in-flight beats with no tile_done pulse.

Structure
REQ-016 Package gemm_pkg SHALL hold the default DATA_W, HOP_LAT and PE_LAT constants and the feeder_state_t enum.
REQ-017 One sub-module skew_delay_line (parameters DEPTH, DATA_W; data+valid shift register with DEPTH=0 meaning a wire, synchronous clear input) SHALL be instantiated once per lane.

Verification
REQ-018 Defaults, K=4, continuous in_valid -> start_tile 1 cycle, in_ready high 4 cycles, a_lane_valid[3] first high 7 cycles after the first accept, tile_done 15 cycles after the last accept, beat_cnt=4.
REQ-019 K=3 with one bubble after beat 0 -> every lane shows valid pattern 1,0,1,1 at its own skew; beat_cnt=3.
REQ-020 K=1, in_a lanes=1,2,3,4 and in_b lanes=5,6,7,8 -> a_lane r carries r+1 at cycle 1+2r; b_lane c carries c+5 at cycle 1+2c; tile_done at +15.
REQ-021 flush asserted in the same cycle as the in_last beat -> IDLE next cycle, no tile_done, all lane valids 0 within 1 cycle.
REQ-022 rst pulse during DRAIN (count=5) -> all outputs 0, no tile_done; a subsequent K=2 tile completes normally.
REQ-023 Two back-to-back tiles -> second start_tile exactly 2 cycles after the first tile_done; beat_cnt restarts at 0.
